// File: rtl/remote_cmd_master_if.sv
// Host and UART-side signal bundle for the remote command initiator.
// The master modport is the initiator's view; slave is the host/UART side.
interface remote_cmd_master_if;
   // host request / response
   logic        snd_cmd;
   logic [7:0]  cmd;
   logic [15:0] data;
   logic        clr_resp_rdy;
   logic        busy;
   logic        cmd_sent;
   logic [7:0]  resp;
   logic        resp_rdy;
   logic        resp_ok;
   logic        tmo;
   // byte-level UART transmitter / receiver
   logic [7:0]  tx_data;
   logic        trmt;
   logic        tx_done;
   logic        rx_rdy;
   logic [7:0]  rx_data;
   logic        clr_rx_rdy;

   modport master (
      input  snd_cmd, cmd, data, clr_resp_rdy, tx_done, rx_rdy, rx_data,
      output busy, cmd_sent, resp, resp_rdy, resp_ok, tmo, tx_data, trmt, clr_rx_rdy
   );

   modport slave (
      output snd_cmd, cmd, data, clr_resp_rdy, tx_done, rx_rdy, rx_data,
      input  busy, cmd_sent, resp, resp_rdy, resp_ok, tmo, tx_data, trmt, clr_rx_rdy
   );
endinterface

// File: rtl/remote_cmd_master.sv
// Remote-side command initiator: frames cmd/data into three UART bytes,
// paces them through the transmitter, then waits for a one-byte response
// with a timeout. Stale receive bytes outside the response window are flushed.
module remote_cmd_master #(
   parameter int unsigned RESP_TMO = 5_000_000,
   parameter logic [7:0]  ACK      = 8'hA5
) (
   input logic                  clk,
   input logic                  rst_n,
   remote_cmd_master_if.master  bus
);

   typedef enum logic [1:0] {IDLE, XMIT, WAIT_TX, WAIT_RESP} state_t;

   localparam logic [23:0] TMO_LAST = 24'(RESP_TMO - 1);

   state_t      state;
   state_t      state_next;

   logic [7:0]  cmd_reg;
   logic [15:0] data_reg;
   logic [1:0]  sel_reg;
   logic [23:0] tmo_cnt_reg;
   logic        cmd_sent_reg;
   logic        tmo_reg;
   logic [7:0]  resp_reg;
   logic        resp_rdy_reg;
   logic        resp_ok_reg;
   logic        clr_rx_reg;

   logic        accept;
   logic        byte_done;
   logic        last_byte;
   logic        got_resp;
   logic        expire;
   logic        rx_avail;

   // The receiver drops rx_rdy one cycle after our acknowledge, so ignore the
   // level during the acknowledge cycle to avoid consuming one byte twice.
   assign rx_avail = bus.rx_rdy & ~clr_rx_reg;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   // Next-state logic and event decode for the datapath
   always_comb begin
      state_next = state;
      accept     = 1'b0;
      byte_done  = 1'b0;
      last_byte  = 1'b0;
      got_resp   = 1'b0;
      expire     = 1'b0;
      case (state)
         IDLE: begin
            if (bus.snd_cmd) begin
               accept     = 1'b1;
               state_next = XMIT;
            end
         end
         XMIT: state_next = WAIT_TX;
         WAIT_TX: begin
            if (bus.tx_done) begin
               byte_done = 1'b1;
               if (sel_reg == 2'd2) begin
                  last_byte  = 1'b1;
                  state_next = WAIT_RESP;
               end else begin
                  state_next = XMIT;
               end
            end
         end
         WAIT_RESP: begin
            // A response on the terminal count wins over the timeout.
            if (rx_avail) begin
               got_resp   = 1'b1;
               state_next = IDLE;
            end else if (tmo_cnt_reg == TMO_LAST) begin
               expire     = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Capture, byte index, timeout counter and response/status registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cmd_reg      <= 8'h00;
         data_reg     <= 16'h0000;
         sel_reg      <= 2'd0;
         tmo_cnt_reg  <= 24'd0;
         cmd_sent_reg <= 1'b0;
         tmo_reg      <= 1'b0;
         resp_reg     <= 8'h00;
         resp_rdy_reg <= 1'b0;
         resp_ok_reg  <= 1'b0;
         clr_rx_reg   <= 1'b0;
      end else begin
         // Every received byte is acknowledged; only WAIT_RESP keeps it.
         clr_rx_reg <= rx_avail;

         if (accept) begin
            cmd_reg      <= bus.cmd;
            data_reg     <= bus.data;
            sel_reg      <= 2'd0;
            cmd_sent_reg <= 1'b0;
            tmo_reg      <= 1'b0;
         end

         if (byte_done && !last_byte) sel_reg <= sel_reg + 2'd1;

         if (last_byte) begin
            cmd_sent_reg <= 1'b1;
            tmo_cnt_reg  <= 24'd0;
         end else if (state == WAIT_RESP) begin
            tmo_cnt_reg  <= tmo_cnt_reg + 24'd1;
         end

         if (got_resp) begin
            resp_reg    <= bus.rx_data;
            resp_ok_reg <= (bus.rx_data == ACK);
         end

         if (expire) tmo_reg <= 1'b1;

         // Setting beats a host clear; a new request always clears.
         if (got_resp)                        resp_rdy_reg <= 1'b1;
         else if (accept || bus.clr_resp_rdy) resp_rdy_reg <= 1'b0;
      end
   end

   // Outputs: tx_data comes from captured registers so host changes are inert
   always_comb begin
      bus.busy       = (state != IDLE);
      bus.trmt       = (state == XMIT);
      case (sel_reg)
         2'd0:    bus.tx_data = cmd_reg;
         2'd1:    bus.tx_data = data_reg[15:8];
         default: bus.tx_data = data_reg[7:0];
      endcase
      bus.cmd_sent   = cmd_sent_reg;
      bus.tmo        = tmo_reg;
      bus.resp       = resp_reg;
      bus.resp_rdy   = resp_rdy_reg;
      bus.resp_ok    = resp_ok_reg;
      bus.clr_rx_rdy = clr_rx_reg;
   end

endmodule

// File: tb/tb_remote_cmd_master.sv
// Self-checking bench for remote_cmd_master: directed test-plan items plus
// randomized transactions against a transaction-level expectation model.
module tb_remote_cmd_master;

   localparam int unsigned RESP_TMO = 100;
   localparam logic [7:0]  ACK      = 8'hA5;
   localparam int          TX_LAT   = 10;

   logic clk;
   logic rst_n;

   remote_cmd_master_if bus_if ();

   remote_cmd_master #(.RESP_TMO(RESP_TMO), .ACK(ACK)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int         checks   = 0;
   int         failures = 0;
   int         txn_no   = 0;
   int         tx_err   = 0;
   logic [7:0] tx_log[$];
   logic [7:0] held_byte;
   int         tx_cnt;
   logic [7:0] exp_resp;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Transmitter model: tx_done TX_LAT cycles after each trmt; logs bytes,
   // flags tx_data changing or trmt repeating while a byte is in flight.
   initial begin
      bus_if.tx_done = 1'b0;
      tx_cnt = 0;
      held_byte = 8'h00;
      forever begin
         @(negedge clk);
         bus_if.tx_done = 1'b0;
         if (!rst_n) begin
            tx_cnt = 0;
         end else if (tx_cnt != 0) begin
            if (bus_if.tx_data !== held_byte) tx_err++;
            if (bus_if.trmt !== 1'b0) tx_err++;
            tx_cnt--;
            if (tx_cnt == 0) bus_if.tx_done = 1'b1;
         end else if (bus_if.trmt === 1'b1) begin
            tx_log.push_back(bus_if.tx_data);
            held_byte = bus_if.tx_data;
            tx_cnt = TX_LAT;
         end
      end
   end

   task automatic check_all_zero(input string pfx);
      check_val({pfx, "_busy"},     bus_if.busy,       0);
      check_val({pfx, "_cmd_sent"}, bus_if.cmd_sent,   0);
      check_val({pfx, "_resp"},     bus_if.resp,       0);
      check_val({pfx, "_resp_rdy"}, bus_if.resp_rdy,   0);
      check_val({pfx, "_resp_ok"},  bus_if.resp_ok,    0);
      check_val({pfx, "_tmo"},      bus_if.tmo,        0);
      check_val({pfx, "_tx_data"},  bus_if.tx_data,    0);
      check_val({pfx, "_trmt"},     bus_if.trmt,       0);
      check_val({pfx, "_clr_rx"},   bus_if.clr_rx_rdy, 0);
   endtask

   // One full transaction. Expected bytes and outcome come from the request
   // and the chosen response alone.
   task automatic run_txn(input logic [7:0] c, input logic [15:0] d,
                          input bit has_resp, input logic [7:0] rb, input int delay,
                          input bit stale, input bit poke,
                          input bit clr_with_set, input bit clr_after, input bit clr_with_snd);
      int         n;
      int         cyc;
      bit         stale_clr;
      logic [7:0] exp_bytes[3];
      string      outcome;

      exp_bytes[0] = c;
      exp_bytes[1] = d[15:8];
      exp_bytes[2] = d[7:0];
      txn_no++;

      n = 0;
      while (bus_if.busy && n < 1000) begin @(negedge clk); n++; end
      check_val("idle_before_req", bus_if.busy, 0);

      tx_log.delete();
      tx_err = 0;
      bus_if.cmd = c;
      bus_if.data = d;
      bus_if.snd_cmd = 1'b1;
      bus_if.clr_resp_rdy = clr_with_snd;
      @(negedge clk);
      bus_if.snd_cmd = 1'b0;
      bus_if.clr_resp_rdy = 1'b0;
      check_val("accept_busy",     bus_if.busy,     1);
      check_val("accept_trmt",     bus_if.trmt,     1);
      check_val("accept_tx_data",  bus_if.tx_data,  c);
      check_val("accept_cmd_sent", bus_if.cmd_sent, 0);
      check_val("accept_tmo",      bus_if.tmo,      0);
      check_val("accept_resp_rdy", bus_if.resp_rdy, 0);
      // host inputs wander mid-transaction; they must not leak into tx_data
      bus_if.cmd  = 8'($urandom);
      bus_if.data = 16'($urandom);

      cyc = 0;
      stale_clr = 1'b0;
      while (!bus_if.cmd_sent && cyc < 200) begin
         @(negedge clk);
         cyc++;
         bus_if.snd_cmd = 1'b0;
         if (poke && cyc == 3) begin
            bus_if.cmd = 8'h06;
            bus_if.data = 16'($urandom);
            bus_if.snd_cmd = 1'b1;
         end
         if (stale && bus_if.rx_rdy && bus_if.clr_rx_rdy) begin
            bus_if.rx_rdy = 1'b0;
            stale_clr = 1'b1;
            check_val("stale_resp_kept", bus_if.resp, exp_resp);
         end
         if (stale && cyc == 5) begin
            bus_if.rx_data = ~exp_resp;
            bus_if.rx_rdy = 1'b1;
         end
      end
      bus_if.snd_cmd = 1'b0;
      bus_if.rx_rdy = 1'b0;
      check_val("cmd_sent_seen", bus_if.cmd_sent, 1);
      check_val("tx_byte_count", tx_log.size(), 3);
      for (int i = 0; i < 3; i++)
         check_val($sformatf("tx_byte%0d", i), (tx_log.size() > i) ? tx_log[i] : 8'hxx, exp_bytes[i]);
      check_val("tx_hold_errors", tx_err, 0);
      if (stale) check_val("stale_flushed", stale_clr, 1);
      check_val("sending_busy", bus_if.busy, 1);

      if (has_resp) begin
         repeat (delay) @(negedge clk);
         bus_if.rx_data = rb;
         bus_if.rx_rdy = 1'b1;
         bus_if.clr_resp_rdy = clr_with_set;
         @(negedge clk);
         bus_if.rx_rdy = 1'b0;
         bus_if.clr_resp_rdy = 1'b0;
         check_val("resp_clr_rx",  bus_if.clr_rx_rdy, 1);
         check_val("resp_value",   bus_if.resp,       rb);
         check_val("resp_rdy",     bus_if.resp_rdy,   1);
         check_val("resp_ok",      bus_if.resp_ok,    (rb == ACK));
         check_val("resp_busy",    bus_if.busy,       0);
         check_val("resp_tmo",     bus_if.tmo,        0);
         exp_resp = rb;
         outcome = (rb == ACK) ? "ack" : "nak";
      end else begin
         n = 0;
         while (!bus_if.tmo && n < 300) begin @(negedge clk); n++; end
         check_val("tmo_latency",  n,                 RESP_TMO);
         check_val("tmo_flag",     bus_if.tmo,        1);
         check_val("tmo_busy",     bus_if.busy,       0);
         check_val("tmo_resp_rdy", bus_if.resp_rdy,   0);
         check_val("tmo_resp",     bus_if.resp,       exp_resp);
         outcome = "timeout";
      end

      if (clr_after) begin
         bus_if.clr_resp_rdy = 1'b1;
         @(negedge clk);
         bus_if.clr_resp_rdy = 1'b0;
         check_val("host_clear", bus_if.resp_rdy, 0);
      end
      $display("txn %0d cmd=%02h data=%04h resp=%02h delay=%0d stale=%0d poke=%0d -> %s",
               txn_no, c, d, rb, delay, stale, poke, outcome);
   endtask

   initial begin
      int n;
      rst_n = 1'b0;
      exp_resp = 8'h00;
      bus_if.snd_cmd = 1'b0;
      bus_if.cmd = 8'h00;
      bus_if.data = 16'h0000;
      bus_if.clr_resp_rdy = 1'b0;
      bus_if.rx_rdy = 1'b0;
      bus_if.rx_data = 8'h00;
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst_n = 1'b1;
      @(negedge clk);

      // SET_PTCH with ACK, NAK, timeout, then busy/stale SET_YAW
      run_txn(8'h02, 16'h1234, 1, ACK,   5,  0, 0, 0, 0, 0);
      run_txn(8'h05, 16'h00FF, 1, 8'h5A, 3,  0, 0, 0, 0, 0);
      run_txn(8'h03, 16'hC0DE, 0, 8'h00, 0,  0, 0, 0, 0, 0);
      run_txn(8'h04, 16'h5678, 1, ACK,   10, 1, 1, 0, 0, 1);
      // response on the terminal timeout cycle, together with a host clear
      run_txn(8'h0A, 16'hAA55, 1, 8'h33, RESP_TMO - 1, 0, 0, 1, 1, 0);

      // reset after the second trmt of a transaction
      tx_log.delete();
      bus_if.cmd = 8'h09;
      bus_if.data = 16'hBEEF;
      bus_if.snd_cmd = 1'b1;
      @(negedge clk);
      bus_if.snd_cmd = 1'b0;
      n = 0;
      while (tx_log.size() < 2 && n < 100) begin @(negedge clk); n++; end
      check_val("pre_reset_trmts", tx_log.size(), 2);
      #2 rst_n = 1'b0;
      #1 check_all_zero("midrst");
      repeat (3) begin
         @(negedge clk);
         check_val("midrst_no_trmt", bus_if.trmt, 0);
      end
      rst_n = 1'b1;
      exp_resp = 8'h00;
      $display("txn reset applied mid-transaction cmd=09");

      // SET_MOFF after reset, then back-to-back SET_ROLL / SET_THRST
      run_txn(8'h08, 16'h0000, 1, ACK, 7, 0, 0, 0, 0, 0);
      run_txn(8'h01, 16'h0102, 1, ACK, 2, 0, 0, 0, 0, 0);
      run_txn(8'h07, 16'h8000, 1, ACK, 4, 0, 0, 0, 1, 1);

      for (int i = 0; i < 20; i++) begin
         logic [7:0]  rc;
         logic [15:0] rd;
         logic [7:0]  rb;
         bit          hr;
         rc = 8'($urandom);
         rd = 16'($urandom);
         rb = ($urandom_range(0, 1) == 0) ? ACK : 8'($urandom);
         hr = ($urandom_range(0, 4) != 0);
         run_txn(rc, rd, hr, rb, $urandom_range(0, RESP_TMO - 1),
                 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/remote_cmd_master.md
# remote_cmd_master

Remote-side command initiator for the quadcopter UART command link. It takes a host request (8-bit command plus 16-bit data) and frames it into three UART bytes: cmd, data[15:8], data[7:0]. It paces those bytes through a byte-level UART transmitter, then waits for the single response byte that the airframe-side command handler returns. It sits between the remote's host logic and its UART transceiver and adds response validation and a response timeout.

## Interface
Parameters:
- RESP_TMO, default 5_000_000: cycles to wait for a response after the last byte is sent (100 ms at 50 MHz); 24-bit counter.
- ACK, default 8'hA5: response value treated as a positive acknowledge.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- snd_cmd  in  1  one-cycle request to send; honored only when idle.
- cmd  in  8  command opcode, captured on an accepted snd_cmd.
- data  in  16  command data, captured on an accepted snd_cmd.
- clr_resp_rdy  in  1  host clears resp_rdy.
- busy  out  1  high from an accepted snd_cmd until the response is received or the timeout fires.
- cmd_sent  out  1  level; set when the third byte completes, cleared by the next accepted snd_cmd.
- resp  out  8  last response byte received.
- resp_rdy  out  1  level; a valid response is held in resp.
- resp_ok  out  1  resp == ACK; valid while resp_rdy is high.
- tmo  out  1  level; the last transaction timed out. Cleared by the next accepted snd_cmd.
- tx_data  out  8  byte to the UART transmitter.
- trmt  out  1  one-cycle transmit strobe.
- tx_done  in  1  one-cycle pulse from the transmitter when a byte has finished.
- rx_rdy  in  1  level from the UART receiver: a byte is available.
- rx_data  in  8  received byte.
- clr_rx_rdy  out  1  one-cycle acknowledge to the receiver.

## Operation
- States: IDLE, XMIT, WAIT_TX, WAIT_RESP. A 2-bit byte index sel selects the byte: 0 = cmd, 1 = data[15:8], 2 = data[7:0].
- IDLE with snd_cmd:
  - capture cmd and data into internal registers; sel = 0;
  - clear cmd_sent, tmo and resp_rdy;
  - go to XMIT.
- XMIT: assert trmt for one cycle, with tx_data = the selected byte; go to WAIT_TX.
- WAIT_TX on tx_done:
  - if sel < 2: increment sel and return to XMIT;
  - otherwise: set cmd_sent, clear the timeout counter, go to WAIT_RESP.
- WAIT_RESP on rx_rdy:
  - latch rx_data into resp; set resp_rdy;
  - resp_ok = (rx_data == ACK);
  - pulse clr_rx_rdy; go to IDLE.
- WAIT_RESP with no byte: the counter increments every cycle. When the counter equals RESP_TMO-1, set tmo and go to IDLE; resp_rdy stays 0.
- tx_data holds its byte from trmt until the following tx_done. It is driven from the captured registers, so host changes to cmd/data mid-transaction have no effect.
- A byte received while in IDLE, XMIT or WAIT_TX is stale. Pulse clr_rx_rdy and discard it; resp is unchanged.
- snd_cmd while busy is ignored; it is not queued.

## Timing
- Reset: busy, cmd_sent, resp, resp_rdy, resp_ok, tmo, tx_data, trmt and clr_rx_rdy are all 0; state is IDLE. Reset mid-transaction aborts immediately; no further trmt is issued.
- snd_cmd sampled high at edge N (IDLE): busy = 1 and trmt = 1 with tx_data = cmd in cycle N+1.
- tx_done at edge M:
  - next trmt in cycle M+1;
  - after the third byte, cmd_sent = 1 in cycle M+1.
- rx_rdy sampled at edge R in WAIT_RESP: resp, resp_rdy, resp_ok and the clr_rx_rdy pulse all appear in cycle R+1, and busy = 0 in R+1.
- Timeout: tmo = 1 and busy = 0 exactly RESP_TMO cycles after entering WAIT_RESP.
- Simultaneous events:
  - rx_rdy on the terminal timeout cycle: the response wins and tmo stays 0.
  - clr_resp_rdy on the cycle resp_rdy is being set: set wins.
  - clr_resp_rdy and an accepted snd_cmd together: resp_rdy = 0.
- A new snd_cmd is accepted on the first cycle busy is 0, which allows back-to-back transactions.
- trmt is never asserted while in WAIT_TX or WAIT_RESP.

## Test plan
- SET_PTCH: snd_cmd with cmd = 8'h02, data = 16'h1234, and a transmitter model with tx_done 10 cycles after each trmt. Required: tx_data sequence 02, 12, 34; cmd_sent after the third tx_done. Then inject rx_data = A5: resp = A5, resp_rdy = 1, resp_ok = 1, busy = 0.
- Negative acknowledge: cmd = 8'h05, data = 16'h00FF, response 8'h5A. Required: resp_rdy = 1, resp_ok = 0, tmo = 0.
- Timeout with RESP_TMO = 100 and no response: tmo = 1 exactly 100 cycles after cmd_sent rises, busy = 0, resp_rdy = 0. A following snd_cmd clears tmo.
- Busy/stale: snd_cmd (cmd = 8'h06) while a SET_YAW transaction is in WAIT_TX is ignored, and the byte order stays 04, data_hi, data_lo. An rx_rdy during transmit is flushed with clr_rx_rdy and resp is unchanged.
- Reset mid-transaction: assert rst_n low after the second trmt. All outputs go to 0 immediately. After release, a SET_MOFF (8'h08, 16'h0000) completes normally with response A5.
- Back-to-back: issue SET_ROLL then SET_THRST, with snd_cmd in the first idle cycle after resp_rdy. Both complete, and clr_resp_rdy clears resp_rdy.
